// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: shared state encoding and sizing helper for the memory port arbiter.
package memory_port_arbiter_pkg;
  localparam int ARB_STATE_BITS = 2;
  typedef enum logic [ARB_STATE_BITS-1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_DM = 2'd2
  } arb_state_e;
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-outstanding memory port between fetch and data,
// with bounded data bursts while a fetch waits and dropping of killed fetch responses.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_kill,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_fetch_req,
  output logic                    stall_memory_req
);
  localparam int CW = burst_cnt_width(MAX_DATA_BURST);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);
  arb_state_e    state_q, state_d;
  logic          kill_pending_q, kill_pending_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          idle, dm_win, if_win, accept;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      kill_pending_q <= 1'b0;
      burst_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      kill_pending_q <= kill_pending_d;
      burst_cnt_q    <= burst_cnt_d;
    end
  end
  // Data keeps priority until it has taken MAX_DATA_BURST grants in a row over a waiting fetch.
  always_comb begin
    idle   = state_q == ARB_IDLE;
    dm_win = dm_req & (~if_req | (burst_cnt_q < BURST_MAX));
    if_win = if_req & ~dm_win;
    accept = rst_n & idle & (dm_win | if_win) & mem_ready;
  end
  always_comb begin
    state_d        = idle ? (accept ? (dm_win ? ARB_WAIT_DM : ARB_WAIT_IF) : ARB_IDLE)
                          : (mem_rvalid ? ARB_IDLE : state_q);
    kill_pending_d = (state_q == ARB_WAIT_IF) ? (~mem_rvalid & (kill_pending_q | if_kill))
                                              : (kill_pending_q | (accept & if_win & if_kill));
    burst_cnt_d    = ~accept ? burst_cnt_q
                   : (dm_win & if_req) ? ((burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + CW'(1))
                   : '0;
  end
  always_comb begin
    mem_req          = rst_n & idle & (dm_win | if_win);
    mem_we           = mem_req & dm_win & dm_we;
    mem_addr         = dm_win ? dm_addr : if_addr;
    mem_wdata        = dm_win ? dm_wdata : '0;
    mem_be           = dm_win ? dm_be : '1;
    if_valid         = (state_q == ARB_WAIT_IF) & mem_rvalid & ~(kill_pending_q | if_kill);
    dm_valid         = (state_q == ARB_WAIT_DM) & mem_rvalid;
    if_rdata         = mem_rdata;
    dm_rdata         = mem_rdata;
    stall_fetch_req  = if_req & ~if_valid;
    stall_memory_req = dm_req & ~dm_valid;
  end
  // A killed fetch may be abandoned by the fetch stage, so only a live one must hold its request.
  a_dm_hold: assert property (@(posedge clk) disable iff (!rst_n) (state_q == ARB_WAIT_DM) |-> dm_req);
  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_WAIT_IF && !kill_pending_q && !if_kill) |-> if_req);
endmodule
